// File: rtl/band_id_lut_ctrl.sv
// band_id_lut_ctrl: arbitrates lookup and config traffic onto a single-port band-id LUT,
// and provides a whole-table fill ("clear") sequence.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   lookup_valid/addr/ready       lookup request handshake
//   band_id, band_id_valid        registered lookup result with one-cycle strobe
//   cfg_valid/we/addr/wdata/ready config write or read-back request handshake
//   cfg_rdata, cfg_rvalid         registered read-back result with one-cycle strobe
//   clear_start, clear_value      start a fill of every LUT entry with clear_value
//   clear_done, busy              fill-complete pulse, fill-in-progress flag
//   lut_we/addr/din, lut_dout     LUT port; lut_dout valid RD_LAT cycles after lut_addr
module band_id_lut_ctrl #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_ready,
  output logic [DATA_W-1:0] band_id,
  output logic              band_id_valid,
  input  logic              cfg_valid,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_ready,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              cfg_rvalid,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              clear_done,
  output logic              busy,
  output logic              lut_we,
  output logic [ADDR_W-1:0] lut_addr,
  output logic [DATA_W-1:0] lut_din,
  input  logic [DATA_W-1:0] lut_dout
);

  localparam int unsigned StarveW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [0:0] {StIdle, StClear} state_e;
  typedef enum logic [1:0] {TagNone, TagLookup, TagCfgRd} tag_e;

  state_e              state_q;
  logic [StarveW-1:0]  starve_q;
  logic [ADDR_W-1:0]   fill_q;
  logic [DATA_W-1:0]   clr_val_q;
  tag_e                tag_q [RD_LAT];
  tag_e                tag_new;
  logic                in_idle;
  logic                starved;
  logic                lookup_acc;
  logic                cfg_acc;

  // Handshakes. clear_start pre-empts both request types; once a waiting config request
  // has seen STARVE_LIMIT lookup grants it takes priority over lookups.
  always_comb begin
    in_idle      = (state_q == StIdle);
    starved      = (starve_q == StarveMax);
    lookup_ready = in_idle && !clear_start && !(cfg_valid && starved);
    cfg_ready    = in_idle && !clear_start && (!lookup_valid || starved);
    lookup_acc   = lookup_valid && lookup_ready;
    cfg_acc      = cfg_valid && cfg_ready;
    busy         = (state_q == StClear);
  end

  // LUT port is driven straight from the accepted request so the read starts this cycle.
  always_comb begin
    lut_we   = 1'b0;
    lut_addr = '0;
    lut_din  = '0;
    tag_new  = TagNone;
    if (state_q == StClear) begin
      lut_we   = 1'b1;
      lut_addr = fill_q;
      lut_din  = clr_val_q;
    end else if (lookup_acc) begin
      lut_addr = lookup_addr;
      tag_new  = TagLookup;
    end else if (cfg_acc) begin
      lut_addr = cfg_addr;
      lut_we   = cfg_we;
      lut_din  = cfg_we ? cfg_wdata : '0;
      tag_new  = cfg_we ? TagNone : TagCfgRd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      starve_q      <= '0;
      fill_q        <= '0;
      clr_val_q     <= '0;
      band_id       <= '0;
      band_id_valid <= 1'b0;
      cfg_rdata     <= '0;
      cfg_rvalid    <= 1'b0;
      clear_done    <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= TagNone;
    end else begin
      band_id_valid <= 1'b0;
      cfg_rvalid    <= 1'b0;
      clear_done    <= 1'b0;

      // Tag pipeline: the last stage lines up with lut_dout for that request.
      tag_q[0] <= tag_new;
      for (int unsigned i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      unique case (tag_q[RD_LAT-1])
        TagLookup: begin
          band_id       <= lut_dout;
          band_id_valid <= 1'b1;
        end
        TagCfgRd: begin
          cfg_rdata  <= lut_dout;
          cfg_rvalid <= 1'b1;
        end
        default: ;
      endcase

      if (cfg_acc || !cfg_valid) begin
        starve_q <= '0;
      end else if (lookup_acc && !starved) begin
        starve_q <= starve_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (clear_start) begin
            clr_val_q <= clear_value;
            fill_q    <= '0;
            state_q   <= StClear;
          end
        end
        StClear: begin
          // Single pass: leave on the last address rather than wrapping.
          if (fill_q == '1) begin
            state_q    <= StIdle;
            clear_done <= 1'b1;
          end else begin
            fill_q <= fill_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/band_id_lut_ctrl.md
BAND_ID_LUT_CTRL -- requirements
Module: band_id_lut_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 9, LUT address width; DATA_W, default 8, band-id width; RD_LAT, default 1, LUT read latency in cycles (1 or 2); STARVE_LIMIT, default 15, consecutive lookup grants before a waiting config request is forced through.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- lookup_valid  in  1  encoded-pad lookup request
- lookup_addr  in  ADDR_W  encoded logic-pad index
- lookup_ready  out  1  lookup accepted this cycle when high with lookup_valid
- band_id  out  DATA_W  lookup result
- band_id_valid  out  1  one-cycle result strobe
- cfg_valid  in  1  config request
- cfg_we  in  1  1 = write, 0 = read-back
- cfg_addr  in  ADDR_W  config address
- cfg_wdata  in  DATA_W  write data
- cfg_ready  out  1  config accepted when high with cfg_valid
- cfg_rdata  out  DATA_W  read-back data
- cfg_rvalid  out  1  one-cycle read-back strobe
- clear_start  in  1  pulse: fill whole LUT with clear_value
- clear_value  in  DATA_W  fill value, sampled on clear_start
- clear_done  out  1  one-cycle pulse at end of fill
- busy  out  1  high while in CLEAR
- lut_we  out  1  LUT write enable
- lut_addr  out  ADDR_W  LUT address
- lut_din  out  DATA_W  LUT write data
- lut_dout  in  DATA_W  LUT read data, valid RD_LAT cycles after address

Function
REQ-003 SHALL implement the states IDLE and CLEAR only.
REQ-004 SHALL drive lookup_ready = (state==IDLE) && !(cfg_valid && starve_cnt==STARVE_LIMIT), combinationally.
REQ-005 SHALL drive cfg_ready = (state==IDLE) && (!lookup_valid || starve_cnt==STARVE_LIMIT), combinationally; lookup and config SHALL never be accepted in the same cycle.
REQ-006 SHALL maintain starve_cnt: increment (saturating at STARVE_LIMIT) on each lookup accept while cfg_valid is high; clear to 0 on cfg accept or whenever cfg_valid is low.
REQ-007 SHALL drive lut_addr/lut_we/lut_din combinationally from the accepted request in the accept cycle: lookup -> addr=lookup_addr, we=0; cfg write -> addr=cfg_addr, we=1, din=cfg_wdata; cfg read -> addr=cfg_addr, we=0; no accept in IDLE -> we=0, addr=0, din=0.
REQ-008 SHALL track in-flight reads with an RD_LAT-deep tag pipeline (tag = none/lookup/cfg-read) and, RD_LAT cycles after accept, register lut_dout into band_id (lookup) or cfg_rdata (cfg read); the matching strobe SHALL be high for exactly one cycle, RD_LAT+1 cycles after the accept edge.
REQ-009 band_id and cfg_rdata SHALL hold their last value between strobes; cfg writes SHALL produce no strobe.
REQ-010 In IDLE, clear_start SHALL latch clear_value, zero a fill counter and enter CLEAR next cycle; when clear_start and a request are valid together, clear_start wins, both readies SHALL be 0 that cycle and nothing is accepted.
REQ-011 In CLEAR, the block SHALL drive lut_we=1, lut_addr=fill counter, lut_din=latched value, and increment the counter by one per cycle from 0 to 2^ADDR_W-1; both readies SHALL be 0; busy SHALL be 1.
REQ-012 After writing address 2^ADDR_W-1, the block SHALL return to IDLE and pulse clear_done for one cycle (the first IDLE cycle); the counter SHALL NOT wrap to a second pass.
REQ-013 clear_start asserted during CLEAR SHALL be ignored.
REQ-014 Reads accepted before entering CLEAR SHALL still complete and strobe normally.

Reset
REQ-015 On rst, state SHALL be IDLE, and starve_cnt, the fill counter and the tag pipeline SHALL be 0; band_id, cfg_rdata, band_id_valid, cfg_rvalid, clear_done and busy SHALL be 0 from the cycle after rst is sampled.
REQ-016 rst mid-CLEAR SHALL abort the fill without clear_done; rst with reads in flight SHALL drop them with no strobe.

Verification
REQ-017 Reset, then lookup_valid=1, addr=0x05, with LUT[5]=0x3C and RD_LAT=1 -> lut_addr=0x05 in the accept cycle; band_id=0x3C and band_id_valid=1 exactly 2 cycles after the accept.
REQ-018 cfg write addr=0x1FF, data=0xA5, then cfg read addr=0x1FF -> cfg_rvalid after RD_LAT+1 cycles with cfg_rdata=0xA5; band_id_valid stays 0.
REQ-019 lookup_valid held high continuously with cfg_valid high -> cfg accepted on the 16th cycle (after 15 lookup grants); lookup_ready=0 that cycle; starve_cnt returns to 0.
REQ-020 clear_start with clear_value=0x7E -> busy high for 512 cycles, lut_addr 0..511 with lut_we=1, then clear_done for 1 cycle; subsequent lookups at random addresses return 0x7E.
REQ-021 rst asserted at fill address 100 -> no clear_done, busy=0 and readies restored the next cycle; a lookup issued in the cycle before rst produces no band_id_valid.
REQ-022 clear_start in the same cycle as lookup_valid -> lookup not accepted (lookup_ready=0), CLEAR entered; clear_start pulsed again mid-fill -> fill length unchanged at 512.
